// File: rtl/jtframe_romrq_arb.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_romrq_arb
// Purpose  : Shares one SDRAM read channel among four jtframe_romrq-style
//            clients. One requester is granted at a time. Its address is
//            latched and the read is issued to the SDRAM controller. Burst
//            data and strobes are broadcast back to the clients. A one-hot
//            we bus marks the owner. Arbitration resumes after the burst.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SDRAMW      SDRAM word-address width
//   FIXED       0 = round-robin, 1 = fixed priority (slot 0 highest)
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   slot0..3_addr  [in]       client word addresses
//   slot_req       [in]  4    client requests (bit i = client i)
//   slot_we        [out] 4    one-hot owner select
//   dst, din_ok    [out]      data-start / data-ready strobes, gated by busy
//   dout           [out] 16   read data, straight from sdram_din
//   sdram_addr     [out]      latched owner address
//   sdram_rd       [out]      read request to controller
//   sdram_ack/dst/rdy [in]    controller handshake and burst strobes
//   sdram_din      [in]  16   controller read data
// ============================================================================
module jtframe_romrq_arb #(
    parameter int SDRAMW = 22,
    parameter int FIXED  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SDRAMW-1:0] slot0_addr,
    input  logic [SDRAMW-1:0] slot1_addr,
    input  logic [SDRAMW-1:0] slot2_addr,
    input  logic [SDRAMW-1:0] slot3_addr,
    input  logic [3:0]        slot_req,
    output logic [3:0]        slot_we,
    output logic              dst,
    output logic              din_ok,
    output logic [15:0]       dout,
    output logic [SDRAMW-1:0] sdram_addr,
    output logic              sdram_rd,
    input  logic              sdram_ack,
    input  logic              sdram_dst,
    input  logic              sdram_rdy,
    input  logic [15:0]       sdram_din
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    state_t            state_q;
    logic [1:0]        ptr_q;
    logic [3:0]        slot_we_q;
    logic              sdram_rd_q;
    logic [SDRAMW-1:0] addr_q;

    logic              win_vld;
    logic [1:0]        win_idx;
    logic [1:0]        scan_idx;
    logic [SDRAMW-1:0] win_addr;
    logic [1:0]        ptr_d;
    logic              busy;

    // Winner search. The scan runs from the highest offset down so that the
    // lowest offset with a request is the last assignment and therefore wins.
    // Round-robin offsets are relative to ptr_q; fixed priority uses the
    // absolute slot index.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = 2'd0;
        scan_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (FIXED != 0) begin
                scan_idx = 2'(i);
            end else begin
                scan_idx = ptr_q + 2'(i);
            end
            if (slot_req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        win_addr = slot0_addr;
        case (win_idx)
            2'd0:    win_addr = slot0_addr;
            2'd1:    win_addr = slot1_addr;
            2'd2:    win_addr = slot2_addr;
            default: win_addr = slot3_addr;
        endcase
    end

    // 2-bit arithmetic wraps slot 3 back to 0.
    assign ptr_d = win_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            slot_we_q  <= 4'd0;
            sdram_rd_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        addr_q     <= win_addr;
                        slot_we_q  <= 4'b0001 << win_idx;
                        sdram_rd_q <= 1'b1;
                        if (FIXED == 0) begin
                            ptr_q <= ptr_d;
                        end
                        state_q    <= ST_WAIT_ACK;
                    end else begin
                        slot_we_q  <= 4'd0;
                        sdram_rd_q <= 1'b0;
                    end
                end
                // The read is committed once issued: a client dropping req
                // here does not cancel it. The burst must complete so that
                // the controller and the arbiter stay in step.
                ST_WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_rd_q <= 1'b0;
                        if (sdram_rdy) begin
                            slot_we_q <= 4'd0;
                            state_q   <= ST_IDLE;
                        end else begin
                            state_q   <= ST_WAIT_DATA;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (sdram_rdy) begin
                        slot_we_q <= 4'd0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    slot_we_q  <= 4'd0;
                    sdram_rd_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are gated while idle so a stray controller pulse cannot reach
    // a client. busy is already high in the ack cycle, so a dst that
    // coincides with ack is forwarded.
    assign busy       = (state_q != ST_IDLE);
    assign dst        = sdram_dst & busy;
    assign din_ok     = sdram_rdy & busy;
    assign dout       = sdram_din;
    assign slot_we    = slot_we_q;
    assign sdram_rd   = sdram_rd_q;
    assign sdram_addr = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_romrq_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_romrq_arb
// Purpose  : Directed self-checking bench for jtframe_romrq_arb. A
//            round-robin and a fixed-priority instance share the same
//            stimulus. Their state sequences depend only on req!=0 and on
//            the controller handshake, so both run in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_romrq_arb;

    localparam int SDRAMW = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [SDRAMW-1:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0;
    logic [3:0]        req   = 4'd0;
    logic              ack   = 1'b0;
    logic              sdst  = 1'b0;
    logic              srdy  = 1'b0;
    logic [15:0]       sdin  = 16'd0;

    logic [3:0]        we_r, we_f;
    logic              dst_r, dst_f, ok_r, ok_f, rd_r, rd_f;
    logic [15:0]       dout_r, dout_f;
    logic [SDRAMW-1:0] addr_r, addr_f;

    int checks   = 0;
    int failures = 0;

    jtframe_romrq_arb #(.SDRAMW(SDRAMW), .FIXED(0)) u_rr (
        .clk(clk), .rst(rst),
        .slot0_addr(a0), .slot1_addr(a1), .slot2_addr(a2), .slot3_addr(a3),
        .slot_req(req), .slot_we(we_r), .dst(dst_r), .din_ok(ok_r),
        .dout(dout_r), .sdram_addr(addr_r), .sdram_rd(rd_r),
        .sdram_ack(ack), .sdram_dst(sdst), .sdram_rdy(srdy), .sdram_din(sdin)
    );

    jtframe_romrq_arb #(.SDRAMW(SDRAMW), .FIXED(1)) u_fx (
        .clk(clk), .rst(rst),
        .slot0_addr(a0), .slot1_addr(a1), .slot2_addr(a2), .slot3_addr(a3),
        .slot_req(req), .slot_we(we_f), .dst(dst_f), .din_ok(ok_f),
        .dout(dout_f), .sdram_addr(addr_f), .sdram_rd(rd_f),
        .sdram_ack(ack), .sdram_dst(sdst), .sdram_rdy(srdy), .sdram_din(sdin)
    );

    task automatic do_reset();
        rst = 1'b1; ack = 1'b0; sdst = 1'b0; srdy = 1'b0; sdin = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for a grant, then plays one controller transaction:
    // ack after ack_dly idle cycles, dst one cycle after ack, rdy one later.
    // Returns on the IDLE cycle that follows rdy.
    task automatic serve(input int ack_dly,
                         output logic [3:0] weg, output logic [SDRAMW-1:0] ag,
                         output logic [3:0] wefg, output logic [SDRAMW-1:0] afg,
                         output int gap);
        gap = 0;
        while (rd_r !== 1'b1 && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        checks++;
        if (rd_r !== 1'b1) begin
            failures++;
            $display("FAIL serve_grant_timeout got=%b exp=1", rd_r);
        end
        weg = we_r; ag = addr_r; wefg = we_f; afg = addr_f;
        repeat (ack_dly) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; sdst = 1'b1; sdin = 16'hAAAA;
        @(negedge clk);
        sdst = 1'b0; srdy = 1'b1; sdin = 16'h5555;
        @(negedge clk);
        srdy = 1'b0; sdin = 16'd0;
    endtask

    task automatic test_reset();
        do_reset();
        sdst = 1'b1; srdy = 1'b1;
        #1;
        checks++; if (rd_r !== 1'b0)     begin failures++; $display("FAIL reset_rd got=%b exp=0", rd_r); end
        checks++; if (we_r !== 4'd0)     begin failures++; $display("FAIL reset_we got=%b exp=0000", we_r); end
        checks++; if (addr_r !== '0)     begin failures++; $display("FAIL reset_addr got=%h exp=0", addr_r); end
        checks++; if ({dst_r, ok_r} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {dst_r, ok_r}); end
        sdst = 1'b0; srdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        a2 = 22'h12345; req = 4'b0100;
        @(negedge clk);
        checks++; if (rd_r !== 1'b1)       begin failures++; $display("FAIL single_rd got=%b exp=1", rd_r); end
        checks++; if (we_r !== 4'b0100)    begin failures++; $display("FAIL single_we got=%b exp=0100", we_r); end
        checks++; if (addr_r !== 22'h12345) begin failures++; $display("FAIL single_addr got=%h exp=12345", addr_r); end
        repeat (2) @(negedge clk);
        checks++; if (rd_r !== 1'b1)       begin failures++; $display("FAIL single_rd_hold got=%b exp=1", rd_r); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++; if (rd_r !== 1'b0)       begin failures++; $display("FAIL single_rd_after_ack got=%b exp=0", rd_r); end
        repeat (2) @(negedge clk);
        sdst = 1'b1; sdin = 16'hAAAA;
        #1;
        checks++; if (dst_r !== 1'b1 || ok_r !== 1'b0) begin failures++; $display("FAIL single_dst got=%b%b exp=10", dst_r, ok_r); end
        checks++; if (dout_r !== 16'hAAAA) begin failures++; $display("FAIL single_dout0 got=%h exp=aaaa", dout_r); end
        @(negedge clk);
        sdst = 1'b0; srdy = 1'b1; sdin = 16'h5555; req = 4'd0;
        #1;
        checks++; if (ok_r !== 1'b1)       begin failures++; $display("FAIL single_din_ok got=%b exp=1", ok_r); end
        checks++; if (dout_r !== 16'h5555) begin failures++; $display("FAIL single_dout1 got=%h exp=5555", dout_r); end
        checks++; if (we_r !== 4'b0100)    begin failures++; $display("FAIL single_we_at_rdy got=%b exp=0100", we_r); end
        @(negedge clk);
        srdy = 1'b0; sdin = 16'd0;
        #1;
        checks++; if (we_r !== 4'd0)       begin failures++; $display("FAIL single_we_drop got=%b exp=0000", we_r); end
        @(negedge clk);
        checks++; if (rd_r !== 1'b0)       begin failures++; $display("FAIL single_no_regrant got=%b exp=0", rd_r); end
    endtask

    task automatic test_arbitration();
        logic [SDRAMW-1:0] aexp [4];
        logic [3:0]        weg, wefg;
        logic [SDRAMW-1:0] ag, afg;
        int                gap, slot;
        int                rr_order [2];
        do_reset();
        a0 = 22'h0A000; a1 = 22'h1B111; a2 = 22'h2C222; a3 = 22'h3D333;
        aexp[0] = 22'h0A000; aexp[1] = 22'h1B111; aexp[2] = 22'h2C222; aexp[3] = 22'h3D333;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve(1, weg, ag, wefg, afg, gap);
            slot = k % 4;
            checks++; if (weg !== 4'(1 << slot)) begin failures++; $display("FAIL rr_we k=%0d got=%b exp=%b", k, weg, 4'(1 << slot)); end
            checks++; if (ag !== aexp[slot])     begin failures++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, ag, aexp[slot]); end
            checks++; if (wefg !== 4'b0001)      begin failures++; $display("FAIL fixed_we k=%0d got=%b exp=0001", k, wefg); end
            checks++; if (afg !== aexp[0])       begin failures++; $display("FAIL fixed_addr k=%0d got=%h exp=%h", k, afg, aexp[0]); end
            checks++; if (gap !== 1)             begin failures++; $display("FAIL turnaround k=%0d got=%0d exp=1", k, gap); end
        end
        // Slot 0 drops: fixed priority moves to slot 1, round-robin continues
        // from the pointer left after the last slot-0 grant.
        req = 4'b1110;
        rr_order[0] = 1; rr_order[1] = 2;
        for (int k = 0; k < 2; k++) begin
            serve(0, weg, ag, wefg, afg, gap);
            checks++; if (wefg !== 4'b0010) begin failures++; $display("FAIL fixed_drop0_we k=%0d got=%b exp=0010", k, wefg); end
            checks++; if (afg !== aexp[1])  begin failures++; $display("FAIL fixed_drop0_addr k=%0d got=%h exp=%h", k, afg, aexp[1]); end
            checks++; if (weg !== 4'(1 << rr_order[k])) begin failures++; $display("FAIL rr_drop0_we k=%0d got=%b exp=%b", k, weg, 4'(1 << rr_order[k])); end
        end
        req = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_owner_drop();
        req = 4'b1000;
        @(negedge clk);
        checks++; if (rd_r !== 1'b1 || we_r !== 4'b1000) begin failures++; $display("FAIL drop_grant got=%b/%b exp=1/1000", rd_r, we_r); end
        req = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (rd_r !== 1'b1)    begin failures++; $display("FAIL drop_rd_held got=%b exp=1", rd_r); end
        checks++; if (we_r !== 4'b1000) begin failures++; $display("FAIL drop_we_held got=%b exp=1000", we_r); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        srdy = 1'b1;
        #1;
        checks++; if (we_r !== 4'b1000 || ok_r !== 1'b1) begin failures++; $display("FAIL drop_we_at_rdy got=%b/%b exp=1000/1", we_r, ok_r); end
        @(negedge clk);
        srdy = 1'b0;
        checks++; if (we_r !== 4'd0)    begin failures++; $display("FAIL drop_we_clear got=%b exp=0000", we_r); end
        @(negedge clk);
        checks++; if (rd_r !== 1'b0)    begin failures++; $display("FAIL drop_no_regrant got=%b exp=0", rd_r); end
        req = 4'b0010;
        @(negedge clk);
        checks++; if (we_r !== 4'b0010 || addr_r !== a1) begin failures++; $display("FAIL drop_next_grant got=%b/%h exp=0010/%h", we_r, addr_r, a1); end
        // Ack and rdy in the same cycle return straight to idle.
        req = 4'd0; ack = 1'b1; srdy = 1'b1;
        @(negedge clk);
        ack = 1'b0; srdy = 1'b0;
        checks++; if (we_r !== 4'd0 || rd_r !== 1'b0) begin failures++; $display("FAIL ack_rdy_same got=%b/%b exp=0000/0", we_r, rd_r); end
        @(negedge clk);
    endtask

    task automatic test_spurious();
        req = 4'd0;
        @(negedge clk);
        sdst = 1'b1; srdy = 1'b1; sdin = 16'hBEEF;
        #1;
        checks++; if ({dst_r, ok_r, dst_f, ok_f} !== 4'b0000) begin failures++; $display("FAIL spurious_strobes got=%b exp=0000", {dst_r, ok_r, dst_f, ok_f}); end
        checks++; if (dout_r !== 16'hBEEF) begin failures++; $display("FAIL spurious_dout got=%h exp=beef", dout_r); end
        @(negedge clk);
        sdst = 1'b0; srdy = 1'b0; sdin = 16'd0;
        checks++; if (we_r !== 4'd0 || rd_r !== 1'b0) begin failures++; $display("FAIL spurious_state got=%b/%b exp=0000/0", we_r, rd_r); end
    endtask

    task automatic test_reset_mid();
        req = 4'b0001;
        @(negedge clk);
        checks++; if (we_r !== 4'b0001) begin failures++; $display("FAIL rstmid_grant got=%b exp=0001", we_r); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (we_r !== 4'd0 || rd_r !== 1'b0) begin failures++; $display("FAIL rstmid_clear got=%b/%b exp=0000/0", we_r, rd_r); end
        checks++; if (addr_r !== '0)    begin failures++; $display("FAIL rstmid_addr got=%h exp=0", addr_r); end
        // Pointer was 1 before reset; a post-reset grant to slot 0 with all
        // four requesting shows it returned to 0.
        rst = 1'b0; req = 4'b1111;
        @(negedge clk);
        checks++; if (rd_r !== 1'b1 || we_r !== 4'b0001) begin failures++; $display("FAIL rstmid_regrant got=%b/%b exp=1/0001", rd_r, we_r); end
        checks++; if (addr_r !== a0)    begin failures++; $display("FAIL rstmid_regrant_addr got=%h exp=%h", addr_r, a0); end
        req = 4'd0; ack = 1'b1; srdy = 1'b1;
        @(negedge clk);
        ack = 1'b0; srdy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_arbitration();
        test_owner_drop();
        test_spurious();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/jtframe_romrq_arb.md
# jtframe_romrq_arb

Four-port arbiter that shares one SDRAM read channel among up to four `jtframe_romrq`-style clients. It grants one requester at a time and latches that client's address. It issues the read to the SDRAM controller, steers the 16-bit burst data and strobes back to the owner through a one-hot `we` bus, then returns to arbitration. The block sits between the per-ROM request caches and the SDRAM bank controller.

## Interface
Parameters:
- `SDRAMW`, 22, SDRAM address width.
- `FIXED`, 0: 0 selects round-robin; 1 selects fixed priority, where slot 0 is highest and slot 3 lowest.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `slot0_addr`..`slot3_addr`  in  SDRAMW each  client SDRAM word addresses (client `sdram_addr`).
- `slot_req`  in  4  client requests, bit i = client i `req`.
- `slot_we`  out  4  one-hot owner select, bit i drives client i `we`.
- `dst`  out  1  data-start strobe, broadcast to all clients.
- `din_ok`  out  1  data-ready strobe, broadcast to all clients.
- `dout`  out  16  read data, broadcast to all clients (client `din`).
- `sdram_addr`  out  SDRAMW  latched address of the current owner.
- `sdram_rd`  out  1  read request to the controller.
- `sdram_ack`  in  1  controller accepted the request.
- `sdram_dst`  in  1  first word of the 32-bit burst is on `sdram_din`.
- `sdram_rdy`  in  1  last (second) word is on `sdram_din`; transaction done.
- `sdram_din`  in  16  controller read data.

## Operation
- Three states:
  - IDLE
  - WAIT_ACK
  - WAIT_DATA
- IDLE:
  - If `slot_req != 0`, pick winner w and latch `slot<w>_addr` into `sdram_addr`.
  - Set `slot_we = 1<<w`, set `sdram_rd = 1`, go to WAIT_ACK.
  - Otherwise stay in IDLE; `slot_we = 0`, `sdram_rd = 0`.
- Winner selection:
  - Round-robin: scan from pointer `ptr` (2 bits) upward mod 4; the first set bit wins. On each grant, `ptr <= w+1` (mod 4, so 3 wraps to 0).
  - FIXED=1: lowest set index wins, and `ptr` is unused.
- WAIT_ACK:
  - Hold `sdram_rd` and `sdram_addr` until `sdram_ack`.
  - On ack: `sdram_rd <= 0`, go to WAIT_DATA.
  - If `sdram_rdy` arrives in the same cycle as ack, go straight to IDLE.
  - The request is never withdrawn, even if the owner's `slot_req` drops. A committed read always completes.
- WAIT_DATA: on `sdram_rdy`, clear `slot_we` and go to IDLE.
- Pass-through:
  - `dout = sdram_din`, combinational.
  - `dst = sdram_dst && busy`, where busy means the state is not IDLE.
  - `din_ok = sdram_rdy && busy`.
  - Strobes are gated in IDLE; a stray controller strobe never reaches clients.
- Clients that are not the owner see `we = 0` and ignore the broadcast strobes.
- An address change by the owner mid-transaction is a client protocol violation. The arbiter still uses the latched address.

## Timing
- Reset values: state IDLE, `ptr = 0`, `slot_we = 0`, `sdram_rd = 0`, `sdram_addr = 0`. `dst`/`din_ok` are 0 because they are gated.
- Reset asserted mid-transaction: all of the above take effect on the next edge, and the in-flight burst is abandoned. The controller shares the same reset.
- Grant latency: `slot_req` seen in IDLE at edge N gives `sdram_rd` and `slot_we` high from N+1.
- `slot_we` stays high from N+1 through the cycle in which `sdram_rdy` is high, inclusive, and is low on the next cycle.
- Turnaround: the earliest next `sdram_rd` is 2 cycles after the `sdram_rdy` cycle (one IDLE evaluation cycle). This lets the client's cache update and drop `req` before re-arbitration.
- Back-to-back demand with the controller acking immediately: one grant every 3 + (controller latency) cycles; no slot starves.
- Round-robin bound: with all four requesting, any slot waits at most 3 full transactions.
- `sdram_dst` may coincide with `sdram_ack`; it is forwarded because `busy` is already high.

## Test plan
- Reset, then `slot_req = 4'b0100`, addr2 = 0x12345, controller acks after 2 cycles and gives dst/rdy 3 and 4 cycles after ack:
  - `sdram_rd` and `slot_we = 0100` one cycle after req, with `sdram_addr = 0x12345`.
  - `dst` and `din_ok` are forwarded with `sdram_din` values 0xAAAA and 0x5555.
  - `slot_we` drops the cycle after rdy.
- All four requesting continuously, FIXED=0: grant order 0,1,2,3,0, each grant with its own latched address.
- Same stimulus with FIXED=1 and slot 0 never dropping req: every grant goes to slot 0. Then drop slot 0: grants go to slot 1.
- Owner drops `slot_req` during WAIT_ACK:
  - `sdram_rd` is held until ack.
  - `slot_we` is held through rdy.
  - The next grant happens only afterwards.
- Spurious `sdram_dst` and `sdram_rdy` pulses while IDLE: `dst = din_ok = 0` and `slot_we = 0`.
- `rst` pulsed in WAIT_DATA: next cycle `slot_we = 0`, `sdram_rd = 0`, `ptr = 0`. A new request is granted normally afterwards.
